alu_ctrl_stage: RTL and testbench
=================================

ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
- REQ-001 SHALL have parameter CTRL_W, default 5, width of alucontrol encoding.
- REQ-002 SHALL have parameter MULT_CYCLES, default 2, occupancy of MULT/MULTU in cycles (1..16).
- REQ-003 SHALL have parameter DIV_CYCLES, default 8, occupancy of DIV/DIVU in cycles (1..16).
- REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
- REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
- REQ-006 SHALL have port stall  input  1  pipeline hold request from hazard unit.
- REQ-007 SHALL have port flush  input  1  kill in-flight decode and busy state.
- REQ-008 SHALL have port valid_i  input  1  aluop/funct carry a real instruction.
- REQ-009 SHALL have port aluop  input  4  main-decoder ALU class.
- REQ-010 SHALL have port funct  input  6  R-type function field.
- REQ-011 SHALL have port alucontrol  output  CTRL_W  registered ALU operation.
- REQ-012 SHALL have port valid_o  output  1  alucontrol is live.
- REQ-013 SHALL have port muldiv_busy  output  1  stall request while mult/div occupies the unit.
- REQ-014 SHALL have port illegal_o  output  1  unrecognised aluop/funct (ALU_ILLEGAL_EN only).

Function
- REQ-015 SHALL decode aluop/funct combinationally with the existing mapping: ANDI/XORI/LUI/ORI/ADDI/ADDIU/SLTI/SLTIU to their controls, MEM to ADD, MFC0/MTC0 to their controls, R-type via funct for all 24 logic/shift/move/arith/mult/div functs; anything else decodes to 0.
- REQ-016 SHALL register decode result into alucontrol/valid_o on the rising edge: latency exactly 1 cycle.
- REQ-017 SHALL hold alucontrol and valid_o unchanged while stall=1 or muldiv_busy=1 (no capture).
- REQ-018 SHALL, on flush=1 (not rst), clear alucontrol and valid_o to 0 and force FSM to IDLE; flush overrides stall and busy.
- REQ-019 SHALL implement FSM IDLE/BUSY with 4-bit down-counter cnt.
- REQ-020 SHALL, in IDLE, on capture of valid MULT/MULTU with MULT_CYCLES>1, go BUSY with cnt=MULT_CYCLES-2; likewise DIV/DIVU with DIV_CYCLES-2.
- REQ-021 SHALL, in BUSY, decrement cnt every cycle regardless of stall; at cnt=0 return to IDLE next edge.
- REQ-022 SHALL drive muldiv_busy=1 exactly when state=BUSY (registered, no combinational path from inputs).
- REQ-023 SHALL treat latency parameter 1 as no BUSY entry.
- REQ-024 SHALL, when valid_i=0 at capture, load alucontrol=0, valid_o=0, no FSM change.

Reset
- REQ-025 SHALL, on rst=1 at a rising edge, set alucontrol=0, valid_o=0, muldiv_busy=0, illegal_o=0, state=IDLE, cnt=0; rst overrides flush and stall.
- REQ-026 SHALL abort a BUSY sequence mid-count on rst or flush with no residual busy cycle.

Configuration
- REQ-027 SHALL compile illegal-op detection only under macro ALU_ILLEGAL_EN: when defined, illegal_o is registered alongside alucontrol, =1 for valid_i=1 with unmapped aluop or unmapped R-type funct, cleared by rst/flush, held under stall/busy.
- REQ-028 SHALL, without ALU_ILLEGAL_EN, tie illegal_o to 0 and omit its logic.

Structure
- REQ-029 SHALL take all *_OP, funct and *_CONTROL constants from the shared configs header; no local literals for encodings.
- REQ-030 SHALL place FSM state encodings in the shared header.
- REQ-031 SHALL factor combinational decode into sub-module alu_ctrl_decode (aluop, funct -> control, is_mult, is_div, illegal).

Verification
- REQ-032 SHALL cover: ADDI_OP, valid_i=1 -> next edge alucontrol=ADD_CONTROL, valid_o=1.
- REQ-033 SHALL cover: R-type DIV, DIV_CYCLES=8 -> muldiv_busy high exactly 7 cycles starting one cycle after capture; outputs held throughout.
- REQ-034 SHALL cover: R-type MULT with stall=1 for 3 cycles during BUSY -> busy still ends after MULT_CYCLES-1 cycles.
- REQ-035 SHALL cover: flush asserted on 3rd BUSY cycle of DIVU -> next edge muldiv_busy=0, valid_o=0, alucontrol=0.
- REQ-036 SHALL cover: rst with stall=1 and flush=1 simultaneously -> all outputs 0 next edge.
- REQ-037 SHALL cover: ALU_ILLEGAL_EN defined, R-type funct=6'b111111 valid -> illegal_o=1, alucontrol=0; undefined -> illegal_o=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: main-decoder aluop classes,
// R-type funct codes, ALU control codes and the mult/div occupancy FSM states.
package alu_ctrl_pkg;

    localparam int ALUOP_W    = 4;
    localparam int FUNCT_W    = 6;
    localparam int CTRL_ENC_W = 5;
    localparam int CNT_W      = 4;

    // Main-decoder ALU classes
    localparam logic [ALUOP_W-1:0] MEM_OP    = 4'b0000;
    localparam logic [ALUOP_W-1:0] R_TYPE_OP = 4'b0010;
    localparam logic [ALUOP_W-1:0] ADDI_OP   = 4'b0011;
    localparam logic [ALUOP_W-1:0] ADDIU_OP  = 4'b0100;
    localparam logic [ALUOP_W-1:0] ANDI_OP   = 4'b0101;
    localparam logic [ALUOP_W-1:0] ORI_OP    = 4'b0110;
    localparam logic [ALUOP_W-1:0] XORI_OP   = 4'b0111;
    localparam logic [ALUOP_W-1:0] LUI_OP    = 4'b1000;
    localparam logic [ALUOP_W-1:0] SLTI_OP   = 4'b1001;
    localparam logic [ALUOP_W-1:0] SLTIU_OP  = 4'b1010;
    localparam logic [ALUOP_W-1:0] MFC0_OP   = 4'b1011;
    localparam logic [ALUOP_W-1:0] MTC0_OP   = 4'b1100;

    // R-type function field
    localparam logic [FUNCT_W-1:0] SLL_FUNCT   = 6'b000000;
    localparam logic [FUNCT_W-1:0] SRL_FUNCT   = 6'b000010;
    localparam logic [FUNCT_W-1:0] SRA_FUNCT   = 6'b000011;
    localparam logic [FUNCT_W-1:0] SLLV_FUNCT  = 6'b000100;
    localparam logic [FUNCT_W-1:0] SRLV_FUNCT  = 6'b000110;
    localparam logic [FUNCT_W-1:0] SRAV_FUNCT  = 6'b000111;
    localparam logic [FUNCT_W-1:0] MFHI_FUNCT  = 6'b010000;
    localparam logic [FUNCT_W-1:0] MTHI_FUNCT  = 6'b010001;
    localparam logic [FUNCT_W-1:0] MFLO_FUNCT  = 6'b010010;
    localparam logic [FUNCT_W-1:0] MTLO_FUNCT  = 6'b010011;
    localparam logic [FUNCT_W-1:0] MULT_FUNCT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] MULTU_FUNCT = 6'b011001;
    localparam logic [FUNCT_W-1:0] DIV_FUNCT   = 6'b011010;
    localparam logic [FUNCT_W-1:0] DIVU_FUNCT  = 6'b011011;
    localparam logic [FUNCT_W-1:0] ADD_FUNCT   = 6'b100000;
    localparam logic [FUNCT_W-1:0] ADDU_FUNCT  = 6'b100001;
    localparam logic [FUNCT_W-1:0] SUB_FUNCT   = 6'b100010;
    localparam logic [FUNCT_W-1:0] SUBU_FUNCT  = 6'b100011;
    localparam logic [FUNCT_W-1:0] AND_FUNCT   = 6'b100100;
    localparam logic [FUNCT_W-1:0] OR_FUNCT    = 6'b100101;
    localparam logic [FUNCT_W-1:0] XOR_FUNCT   = 6'b100110;
    localparam logic [FUNCT_W-1:0] NOR_FUNCT   = 6'b100111;
    localparam logic [FUNCT_W-1:0] SLT_FUNCT   = 6'b101010;
    localparam logic [FUNCT_W-1:0] SLTU_FUNCT  = 6'b101011;

    // ALU control codes; 0 is reserved for "no operation"
    localparam logic [CTRL_ENC_W-1:0] ADD_CONTROL   = 5'd1;
    localparam logic [CTRL_ENC_W-1:0] ADDU_CONTROL  = 5'd2;
    localparam logic [CTRL_ENC_W-1:0] SUB_CONTROL   = 5'd3;
    localparam logic [CTRL_ENC_W-1:0] SUBU_CONTROL  = 5'd4;
    localparam logic [CTRL_ENC_W-1:0] AND_CONTROL   = 5'd5;
    localparam logic [CTRL_ENC_W-1:0] OR_CONTROL    = 5'd6;
    localparam logic [CTRL_ENC_W-1:0] XOR_CONTROL   = 5'd7;
    localparam logic [CTRL_ENC_W-1:0] NOR_CONTROL   = 5'd8;
    localparam logic [CTRL_ENC_W-1:0] SLT_CONTROL   = 5'd9;
    localparam logic [CTRL_ENC_W-1:0] SLTU_CONTROL  = 5'd10;
    localparam logic [CTRL_ENC_W-1:0] SLL_CONTROL   = 5'd11;
    localparam logic [CTRL_ENC_W-1:0] SRL_CONTROL   = 5'd12;
    localparam logic [CTRL_ENC_W-1:0] SRA_CONTROL   = 5'd13;
    localparam logic [CTRL_ENC_W-1:0] SLLV_CONTROL  = 5'd14;
    localparam logic [CTRL_ENC_W-1:0] SRLV_CONTROL  = 5'd15;
    localparam logic [CTRL_ENC_W-1:0] SRAV_CONTROL  = 5'd16;
    localparam logic [CTRL_ENC_W-1:0] LUI_CONTROL   = 5'd17;
    localparam logic [CTRL_ENC_W-1:0] MFHI_CONTROL  = 5'd18;
    localparam logic [CTRL_ENC_W-1:0] MTHI_CONTROL  = 5'd19;
    localparam logic [CTRL_ENC_W-1:0] MFLO_CONTROL  = 5'd20;
    localparam logic [CTRL_ENC_W-1:0] MTLO_CONTROL  = 5'd21;
    localparam logic [CTRL_ENC_W-1:0] MULT_CONTROL  = 5'd22;
    localparam logic [CTRL_ENC_W-1:0] MULTU_CONTROL = 5'd23;
    localparam logic [CTRL_ENC_W-1:0] DIV_CONTROL   = 5'd24;
    localparam logic [CTRL_ENC_W-1:0] DIVU_CONTROL  = 5'd25;
    localparam logic [CTRL_ENC_W-1:0] MFC0_CONTROL  = 5'd26;
    localparam logic [CTRL_ENC_W-1:0] MTC0_CONTROL  = 5'd27;

    // Mult/div occupancy FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct -> ALU control decode. Also flags mult/div
// operations (they occupy the unit for several cycles) and unmapped encodings.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  control,
    output logic               is_mult,
    output logic               is_div,
    output logic               illegal
);

    logic [CTRL_ENC_W-1:0] ctrl_raw;

    // Full decode table; anything unmapped yields control 0 and illegal=1
    always_comb begin
        ctrl_raw = '0;
        is_mult  = 1'b0;
        is_div   = 1'b0;
        illegal  = 1'b0;
        case (aluop)
            MEM_OP:   ctrl_raw = ADD_CONTROL;
            ADDI_OP:  ctrl_raw = ADD_CONTROL;
            ADDIU_OP: ctrl_raw = ADDU_CONTROL;
            ANDI_OP:  ctrl_raw = AND_CONTROL;
            ORI_OP:   ctrl_raw = OR_CONTROL;
            XORI_OP:  ctrl_raw = XOR_CONTROL;
            LUI_OP:   ctrl_raw = LUI_CONTROL;
            SLTI_OP:  ctrl_raw = SLT_CONTROL;
            SLTIU_OP: ctrl_raw = SLTU_CONTROL;
            MFC0_OP:  ctrl_raw = MFC0_CONTROL;
            MTC0_OP:  ctrl_raw = MTC0_CONTROL;
            R_TYPE_OP: begin
                case (funct)
                    AND_FUNCT:   ctrl_raw = AND_CONTROL;
                    OR_FUNCT:    ctrl_raw = OR_CONTROL;
                    XOR_FUNCT:   ctrl_raw = XOR_CONTROL;
                    NOR_FUNCT:   ctrl_raw = NOR_CONTROL;
                    SLL_FUNCT:   ctrl_raw = SLL_CONTROL;
                    SRL_FUNCT:   ctrl_raw = SRL_CONTROL;
                    SRA_FUNCT:   ctrl_raw = SRA_CONTROL;
                    SLLV_FUNCT:  ctrl_raw = SLLV_CONTROL;
                    SRLV_FUNCT:  ctrl_raw = SRLV_CONTROL;
                    SRAV_FUNCT:  ctrl_raw = SRAV_CONTROL;
                    MFHI_FUNCT:  ctrl_raw = MFHI_CONTROL;
                    MTHI_FUNCT:  ctrl_raw = MTHI_CONTROL;
                    MFLO_FUNCT:  ctrl_raw = MFLO_CONTROL;
                    MTLO_FUNCT:  ctrl_raw = MTLO_CONTROL;
                    ADD_FUNCT:   ctrl_raw = ADD_CONTROL;
                    ADDU_FUNCT:  ctrl_raw = ADDU_CONTROL;
                    SUB_FUNCT:   ctrl_raw = SUB_CONTROL;
                    SUBU_FUNCT:  ctrl_raw = SUBU_CONTROL;
                    SLT_FUNCT:   ctrl_raw = SLT_CONTROL;
                    SLTU_FUNCT:  ctrl_raw = SLTU_CONTROL;
                    MULT_FUNCT:  begin ctrl_raw = MULT_CONTROL;  is_mult = 1'b1; end
                    MULTU_FUNCT: begin ctrl_raw = MULTU_CONTROL; is_mult = 1'b1; end
                    DIV_FUNCT:   begin ctrl_raw = DIV_CONTROL;   is_div  = 1'b1; end
                    DIVU_FUNCT:  begin ctrl_raw = DIVU_CONTROL;  is_div  = 1'b1; end
                    default:     illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign control = CTRL_W'(ctrl_raw);

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage with mult/div occupancy tracking.
// Optional macro ALU_ILLEGAL_EN adds a registered illegal_o flag; without it
// illegal_o is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | unit free; a new decode is captured whenever stall is low
// ST_BUSY | mult/div in progress; cnt_q counts down, outputs held, busy=1
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W      = 5,
    parameter int MULT_CYCLES = 2,
    parameter int DIV_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  alucontrol,
    output logic               valid_o,
    output logic               muldiv_busy,
    output logic               illegal_o
);

    // BUSY lasts LOAD+2 cycles counting the capture cycle, i.e. CYCLES-1 busy cycles
    localparam logic [CNT_W-1:0] MULT_LOAD = (MULT_CYCLES > 1) ? CNT_W'(MULT_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_LOAD  = (DIV_CYCLES  > 1) ? CNT_W'(DIV_CYCLES  - 2) : '0;
    localparam bit MULT_MULTI = (MULT_CYCLES > 1);
    localparam bit DIV_MULTI  = (DIV_CYCLES  > 1);

    alu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_is_mult, dec_is_div, dec_illegal;
    logic              capture;

    alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
        .aluop   (aluop),
        .funct   (funct),
        .control (dec_ctrl),
        .is_mult (dec_is_mult),
        .is_div  (dec_is_div),
        .illegal (dec_illegal)
    );

    assign capture = ~stall & (state_q == ST_IDLE);

    // Output register next-value: capture when free, hold otherwise, flush clears
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (capture) begin
            ctrl_d  = valid_i ? dec_ctrl : '0;
            valid_d = valid_i;
        end
        if (flush) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end
    end

    // Occupancy FSM: the count runs even under stall so busy time is fixed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (capture && valid_i) begin
                if (dec_is_mult && MULT_MULTI) begin
                    state_d = ST_BUSY;
                    cnt_d   = MULT_LOAD;
                end else if (dec_is_div && DIV_MULTI) begin
                    state_d = ST_BUSY;
                    cnt_d   = DIV_LOAD;
                end
            end
        end else begin
            if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign alucontrol  = ctrl_q;
    assign valid_o     = valid_q;
    assign muldiv_busy = (state_q == ST_BUSY);

`ifdef ALU_ILLEGAL_EN
    logic ill_q, ill_d;

    // Illegal flag follows the same capture/hold/flush rules as alucontrol
    always_comb begin
        ill_d = ill_q;
        if (capture) begin
            ill_d = valid_i & dec_illegal;
        end
        if (flush) begin
            ill_d = 1'b0;
        end
    end

    // Illegal flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal_o = ill_q;
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign illegal_o      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage with default parameters.
module tb_alu_ctrl_stage;
    import alu_ctrl_pkg::*;

    localparam int MULT_CYC = 2;
    localparam int DIV_CYC  = 8;
`ifdef ALU_ILLEGAL_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    logic       clk;
    logic       rst, stall, flush, valid_i;
    logic [3:0] aluop;
    logic [5:0] funct;
    logic [4:0] alucontrol;
    logic       valid_o, muldiv_busy, illegal_o;

    typedef struct packed {
        logic [4:0] ctrl;
        logic       vld;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   nbusy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_stage #(.CTRL_W(5), .MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .valid_i     (valid_i),
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alucontrol),
        .valid_o     (valid_o),
        .muldiv_busy (muldiv_busy),
        .illegal_o   (illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction, push its expected result, clock, pop and compare
    task automatic issue(input logic [3:0] op, input logic [5:0] fn, input logic v,
                         input logic [4:0] ectrl, input logic eill, input string tag);
        exp_t e;
        aluop   = op;
        funct   = fn;
        valid_i = v;
        exp_q.push_back('{ctrl: (v ? ectrl : 5'd0), vld: v, ill: (v & eill & ILL_ON)});
        step();
        e = exp_q.pop_front();
        check({tag, ".ctrl"}, 32'(alucontrol), 32'(e.ctrl));
        check({tag, ".vld"},  32'(valid_o),    32'(e.vld));
        check({tag, ".ill"},  32'(illegal_o),  32'(e.ill));
    endtask

    task automatic count_busy(output int n, input logic [4:0] held);
        n = 0;
        for (int g = 0; g < 40 && muldiv_busy; g++) begin
            n++;
            check("busy.held_ctrl", 32'(alucontrol), 32'(held));
            step();
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        valid_i = 1'b1; aluop = ADDI_OP; funct = 6'b0;
        step();
        step();
        check("rst.ctrl", 32'(alucontrol), 32'd0);
        check("rst.vld",  32'(valid_o), 32'd0);
        check("rst.busy", 32'(muldiv_busy), 32'd0);
        check("rst.ill",  32'(illegal_o), 32'd0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;

        issue(ADDI_OP,   6'd0,        1'b1, ADD_CONTROL,   1'b0, "addi");
        issue(ADDIU_OP,  6'd0,        1'b1, ADDU_CONTROL,  1'b0, "addiu");
        issue(ANDI_OP,   6'd0,        1'b1, AND_CONTROL,   1'b0, "andi");
        issue(ORI_OP,    6'd0,        1'b1, OR_CONTROL,    1'b0, "ori");
        issue(XORI_OP,   6'd0,        1'b1, XOR_CONTROL,   1'b0, "xori");
        issue(LUI_OP,    6'd0,        1'b1, LUI_CONTROL,   1'b0, "lui");
        issue(SLTI_OP,   6'd0,        1'b1, SLT_CONTROL,   1'b0, "slti");
        issue(SLTIU_OP,  6'd0,        1'b1, SLTU_CONTROL,  1'b0, "sltiu");
        issue(MEM_OP,    6'd0,        1'b1, ADD_CONTROL,   1'b0, "mem");
        issue(MFC0_OP,   6'd0,        1'b1, MFC0_CONTROL,  1'b0, "mfc0");
        issue(MTC0_OP,   6'd0,        1'b1, MTC0_CONTROL,  1'b0, "mtc0");
        issue(R_TYPE_OP, ADD_FUNCT,   1'b1, ADD_CONTROL,   1'b0, "r_add");
        issue(R_TYPE_OP, SUBU_FUNCT,  1'b1, SUBU_CONTROL,  1'b0, "r_subu");
        issue(R_TYPE_OP, NOR_FUNCT,   1'b1, NOR_CONTROL,   1'b0, "r_nor");
        issue(R_TYPE_OP, SLL_FUNCT,   1'b1, SLL_CONTROL,   1'b0, "r_sll");
        issue(R_TYPE_OP, SRAV_FUNCT,  1'b1, SRAV_CONTROL,  1'b0, "r_srav");
        issue(R_TYPE_OP, MFLO_FUNCT,  1'b1, MFLO_CONTROL,  1'b0, "r_mflo");
        issue(R_TYPE_OP, MTHI_FUNCT,  1'b1, MTHI_CONTROL,  1'b0, "r_mthi");
        issue(R_TYPE_OP, SLTU_FUNCT,  1'b1, SLTU_CONTROL,  1'b0, "r_sltu");
        issue(4'b1111,   6'd0,        1'b1, 5'd0,          1'b1, "bad_op");
        issue(R_TYPE_OP, 6'b111111,   1'b1, 5'd0,          1'b1, "bad_funct");
        issue(ADDI_OP,   6'd0,        1'b0, ADD_CONTROL,   1'b0, "invalid");
        check("idle.busy", 32'(muldiv_busy), 32'd0);

        // Stall holds the registered outputs
        issue(ORI_OP, 6'd0, 1'b1, OR_CONTROL, 1'b0, "pre_stall");
        stall = 1'b1; aluop = XORI_OP;
        step(); step(); step();
        check("stall.ctrl", 32'(alucontrol), 32'(OR_CONTROL));
        check("stall.vld",  32'(valid_o), 32'd1);
        stall = 1'b0;
        step();
        check("unstall.ctrl", 32'(alucontrol), 32'(XOR_CONTROL));

        // DIV occupies DIV_CYC-1 busy cycles, outputs held, then next op captured
        issue(R_TYPE_OP, DIV_FUNCT, 1'b1, DIV_CONTROL, 1'b0, "div");
        aluop = ADDI_OP;
        count_busy(nbusy, DIV_CONTROL);
        check("div.busy_len", 32'(nbusy), 32'(DIV_CYC - 1));
        check("div.held_after", 32'(alucontrol), 32'(DIV_CONTROL));
        step();
        check("div.next_ctrl", 32'(alucontrol), 32'(ADD_CONTROL));

        // MULT with stall during BUSY: busy length unaffected
        issue(R_TYPE_OP, MULT_FUNCT, 1'b1, MULT_CONTROL, 1'b0, "mult");
        stall = 1'b1; aluop = ADDI_OP;
        count_busy(nbusy, MULT_CONTROL);
        check("mult.busy_len", 32'(nbusy), 32'(MULT_CYC - 1));
        for (int k = nbusy; k < 3; k++) step();
        check("mult.stall_ctrl", 32'(alucontrol), 32'(MULT_CONTROL));
        check("mult.stall_busy", 32'(muldiv_busy), 32'd0);
        stall = 1'b0;
        step();
        check("mult.next_ctrl", 32'(alucontrol), 32'(ADD_CONTROL));

        // Flush on the third BUSY cycle of DIVU
        issue(R_TYPE_OP, DIVU_FUNCT, 1'b1, DIVU_CONTROL, 1'b0, "divu");
        valid_i = 1'b0;
        step(); step();
        check("divu.busy3", 32'(muldiv_busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.busy", 32'(muldiv_busy), 32'd0);
        check("flush.vld",  32'(valid_o), 32'd0);
        check("flush.ctrl", 32'(alucontrol), 32'd0);
        step();
        check("flush.no_residual", 32'(muldiv_busy), 32'd0);

        // Reset mid-BUSY together with stall and flush
        issue(R_TYPE_OP, DIV_FUNCT, 1'b1, DIV_CONTROL, 1'b0, "div2");
        step();
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_i = 1'b0;
        check("rst2.busy", 32'(muldiv_busy), 32'd0);
        check("rst2.vld",  32'(valid_o), 32'd0);
        check("rst2.ctrl", 32'(alucontrol), 32'd0);
        check("rst2.ill",  32'(illegal_o), 32'd0);
        step();
        check("rst2.no_residual", 32'(muldiv_busy), 32'd0);

        // Illegal flag cleared by a following legal op
        issue(R_TYPE_OP, 6'b111111, 1'b1, 5'd0, 1'b1, "bad_funct2");
        issue(R_TYPE_OP, AND_FUNCT, 1'b1, AND_CONTROL, 1'b0, "r_and");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
